matmul_mem_bridge: RTL
======================

# matmul_mem_bridge

Memory-side bridge between the `matmul` control/dot-product engine and an external in-order memory bus with grant-based backpressure. `matmul` issues one memory transaction per cycle with `mem_req` high and cannot stall, so this block buffers requests in a small FIFO. It issues them on the external bus when granted, tracks outstanding reads, and returns read data to `matmul` as single-cycle `mem_rdata_vld` pulses in issue order. Lost requests and spurious responses raise sticky error flags.

## Interface
- `MEM_AW`, 16, address width
- `MEM_DW`, 32, data width
- `DEPTH`, 4, request FIFO entries (power of 2, ≥2)
- `MAX_OUT`, 4, max reads outstanding on the external bus (≥1)

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `mem_req` in 1: one transaction per cycle while high.
- `mem_write` in 1: 1 = write, 0 = read.
- `mem_addr` in MEM_AW: transaction address.
- `mem_wdata` in MEM_DW: write data.
- `mem_rdata_vld` out 1: read data valid, one-cycle pulse per read.
- `mem_rdata` out MEM_DW: read data.
- `ext_req` out 1: head-of-FIFO request valid.
- `ext_gnt` in 1: transfer occurs when `ext_req & ext_gnt`.
- `ext_we` out 1: head is a write.
- `ext_addr` out MEM_AW: head address.
- `ext_wdata` out MEM_DW: head write data.
- `ext_rvalid` in 1: read response, in order, ≥1 cycle after its grant.
- `ext_rdata` in MEM_DW: response data.
- `idle` out 1: FIFO empty and no reads outstanding.
- `err_ovf` out 1: sticky, a request was dropped because the FIFO was full.
- `err_rsp` out 1: sticky, `ext_rvalid` arrived with nothing outstanding.

## Operation
- **FIFO entry:** `{we, addr, wdata}`, width `1+MEM_AW+MEM_DW`; `wdata` is don't-care for reads.
- **Count:** occupancy counter, width `$clog2(DEPTH)+1`.
- **Push:** `mem_req` high and (count < DEPTH or pop in the same cycle).
- **Overflow:** `mem_req` high, count == DEPTH and no pop → request dropped, `err_ovf` set. `err_ovf` clears only on reset.
- **External drive:** `ext_we`, `ext_addr` and `ext_wdata` are driven combinationally from the FIFO head.
- **`ext_req`:** `!empty && !(head is read && outstanding == MAX_OUT)`.
  - A read head blocked at MAX_OUT also blocks writes behind it; ordering is strictly FIFO.
- **Pop:** `ext_req & ext_gnt`.
- **Outstanding counter** (width `$clog2(MAX_OUT+1)`):
  - +1 on a popped read.
  - −1 on an accepted `ext_rvalid`.
  - Both in the same cycle → unchanged.
- **Response accepted:** `ext_rvalid` and (outstanding > 0 or a read was popped in an earlier cycle). This reduces to: outstanding > 0, using the registered value.
- **Spurious response:** `ext_rvalid` with outstanding == 0 → data discarded, `err_rsp` set (sticky).
- **Return path:** registers `mem_rdata_vld <= accepted`; `mem_rdata <= ext_rdata` on accept, otherwise hold.
- **Writes** produce no response.
- **`idle`:** combinational, `empty && outstanding == 0`.

State per cycle is FIFO pointers, count, outstanding, the return register and the error flags. There is no separate FSM; the behaviour is fully captured by the counters.

## Timing
- **Reset:** while `rst_n`=0 at a clock edge, all of the following clear:
  - FIFO pointers, count and outstanding → 0.
  - `mem_rdata_vld`, `mem_rdata`, `err_ovf`, `err_rsp` → 0.
  - After reset, `ext_req`=0 and `idle`=1.
- **Reset mid-operation:** queued requests and outstanding reads are forgotten. Any later `ext_rvalid` sets `err_rsp`.
- **Request to bus:** `mem_req` sampled at edge E → `ext_req` high in the cycle after E, earliest.
- **Minimum read round trip:**
  1. Request cycle N.
  2. Grant in N+1.
  3. `ext_rvalid` in N+2.
  4. `mem_rdata_vld` in N+3.
- **Simultaneous push and pop when full:** the push is accepted and count stays at DEPTH.
- **Sustained throughput:** `ext_gnt` held high sustains one transaction per cycle with no overflow.
- **`mem_rdata_vld`** is never high two cycles for one read; back-to-back responses give back-to-back pulses.

## Test plan
- **Single read:** reset, `ext_gnt`=1, response latency 1, read addr 0x0010 with `ext_rdata`=0x12345678 → `ext_req` at N+1 with addr 0x0010, `mem_rdata_vld` pulse with 0x12345678 at N+3, `idle` returns to 1.
- **Streaming:** 8 back-to-back reads (addr 0..7) with `ext_gnt`=1 and latency 2; response data is addr×3 → 8 consecutive `mem_rdata_vld` pulses with data 0,3,…,21 in order; `err_ovf`=0.
- **Backpressure:** `ext_gnt`=0 while 4 writes are pushed → count=4, `ext_req`=1. A 5th request → dropped and `err_ovf`=1. Release the grant → exactly 4 writes appear in order.
- **MAX_OUT limit:** responses withheld, 6 reads issued → exactly 4 grants, then `ext_req`=0. One `ext_rvalid` → the 5th read is granted next cycle.
- **Spurious response:** `ext_rvalid`=1 with nothing outstanding → `err_rsp`=1, `mem_rdata_vld` stays 0.
- **Reset mid-operation:** 2 reads outstanding, assert `rst_n`=0 for 1 cycle → `idle`=1 and flags 0. A subsequent `ext_rvalid` → `err_rsp`=1.

Source files
------------

// File: rtl/matmul_mem_bridge.sv
// matmul_mem_bridge
//   Buffers the non-stallable matmul memory request stream in a small FIFO,
//   issues the head on a grant-handshaked external bus, tracks outstanding
//   reads and returns their data to matmul as single-cycle pulses in order.
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   mem_req/mem_write/mem_addr/mem_wdata   request from matmul (one per cycle)
//   mem_rdata_vld/mem_rdata         registered read return to matmul
//   ext_req/ext_gnt                 external handshake, transfer = req & gnt
//   ext_we/ext_addr/ext_wdata       FIFO head, driven combinationally
//   ext_rvalid/ext_rdata            in-order read responses
//   idle                            FIFO empty and no reads outstanding
//   err_ovf, err_rsp                sticky: dropped request, spurious response
module matmul_mem_bridge #(
  parameter int MEM_AW  = 16,
  parameter int MEM_DW  = 32,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_req,
  input  logic              mem_write,
  input  logic [MEM_AW-1:0] mem_addr,
  input  logic [MEM_DW-1:0] mem_wdata,
  output logic              mem_rdata_vld,
  output logic [MEM_DW-1:0] mem_rdata,
  output logic              ext_req,
  input  logic              ext_gnt,
  output logic              ext_we,
  output logic [MEM_AW-1:0] ext_addr,
  output logic [MEM_DW-1:0] ext_wdata,
  input  logic              ext_rvalid,
  input  logic [MEM_DW-1:0] ext_rdata,
  output logic              idle,
  output logic              err_ovf,
  output logic              err_rsp
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(MAX_OUT + 1);

  // Request storage, one field array per entry member.
  logic [DEPTH-1:0]             fifo_we;
  logic [DEPTH-1:0][MEM_AW-1:0] fifo_addr;
  logic [DEPTH-1:0][MEM_DW-1:0] fifo_wdata;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [OW-1:0] outstanding;

  logic empty, full, head_rd, pop, push, rd_pop, rsp_acc;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign head_rd = !fifo_we[rd_ptr];

  assign ext_we    = fifo_we[rd_ptr];
  assign ext_addr  = fifo_addr[rd_ptr];
  assign ext_wdata = fifo_wdata[rd_ptr];

  // A read head stalled at the outstanding limit holds back everything behind
  // it, so bus order always equals matmul issue order.
  assign ext_req = !empty && !(head_rd && (outstanding == OW'(MAX_OUT)));
  assign pop     = ext_req && ext_gnt;
  // A full FIFO still takes a request when the head leaves in the same cycle.
  assign push    = mem_req && (!full || pop);
  assign rd_pop  = pop && head_rd;
  // Response latency is at least one cycle after the grant, so the registered
  // outstanding count already covers every legitimate response.
  assign rsp_acc = ext_rvalid && (outstanding != '0);

  assign idle = empty && (outstanding == '0);

  // Storage needs no reset: nothing is read from an empty FIFO.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_we[wr_ptr]    <= mem_write;
      fifo_addr[wr_ptr]  <= mem_addr;
      fifo_wdata[wr_ptr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      outstanding   <= '0;
      mem_rdata_vld <= 1'b0;
      mem_rdata     <= '0;
      err_ovf       <= 1'b0;
      err_rsp       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      case ({rd_pop, rsp_acc})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase

      mem_rdata_vld <= rsp_acc;
      if (rsp_acc) mem_rdata <= ext_rdata;

      if (mem_req && full && !pop)               err_ovf <= 1'b1;
      if (ext_rvalid && (outstanding == '0))     err_rsp <= 1'b1;
    end
  end
endmodule
